// File: rtl/nunchuck_responder.sv
// -----------------------------------------------------------------------------
// nunchuck_responder
//
// I2C target that behaves like a Wii Nunchuck: it answers DEV_ADDR. A write
// sets the register pointer, and writing 0x55 at pointer 0xF0 sets init_done.
// A read streams the six-byte joystick/accelerometer/button report.
//
// Ports
//   clk        system clock; every flop uses its rising edge
//   rst        synchronous, active-low reset
//   scl_in     I2C clock line as sampled from the pad (asynchronous)
//   sda_in     I2C data line as sampled from the pad (asynchronous)
//   sda_oe     1 pulls SDA low, 0 releases it (open-drain)
//   stick_x/y  8-bit joystick values
//   accel_x/y/z 10-bit accelerometer values
//   z, c       button states, 1 = pressed
//   busy       high from an address-matched START until STOP, NACK or reset
//   init_done  sticky flag set by the 0x55-at-0xF0 init write
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module nunchuck_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic [9:0] accel_x,
  input  logic [9:0] accel_y,
  input  logic [9:0] accel_z,
  input  logic       z,
  input  logic       c,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic            scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_dly_q, scl_dly_d;
  logic            sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_dly_q, sda_dly_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic            first_q, first_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            init_done_q, init_done_d;
  logic [5:0][7:0] snap_q, snap_d;

  logic            scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]      next_byte;

  // Bus events compare the synchronized line with its one-clock-delayed copy.
  assign scl_rise  =  scl_s2_q & ~scl_dly_q;
  assign scl_fall  = ~scl_s2_q &  scl_dly_q;
  assign start_det =  scl_s2_q &  scl_dly_q &  sda_dly_q & ~sda_s2_q;
  assign stop_det  =  scl_s2_q &  scl_dly_q & ~sda_dly_q &  sda_s2_q;

  // Report byte at pointer p, taken from the frozen snapshot.
  function automatic logic [7:0] report_byte(input logic [7:0] p,
                                             input logic [5:0][7:0] s);
    case (p)
      8'd0:    return s[0];
      8'd1:    return s[1];
      8'd2:    return s[2];
      8'd3:    return s[3];
      8'd4:    return s[4];
      8'd5:    return s[5];
      default: return 8'hFF;
    endcase
  endfunction

  assign next_byte = report_byte(ptr_q, snap_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    scl_s1_d    = scl_in;
    scl_s2_d    = scl_s1_q;
    scl_dly_d   = scl_s2_q;
    sda_s1_d    = sda_in;
    sda_s2_d    = sda_s1_q;
    sda_dly_d   = sda_s2_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    first_d     = first_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    snap_d      = snap_q;

    case (state_q)
      ADDR: begin
        if (scl_rise && bit_cnt_q < 4'd8) begin
          rx_d      = {rx_q[6:0], sda_s2_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          if (rx_q[7:1] == DEV_ADDR) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = rx_q[0];
            first_d  = 1'b1;
            // Freeze the report so the read is coherent even if inputs move.
            if (rx_q[0]) begin
              snap_d[0] = stick_x;
              snap_d[1] = stick_y;
              snap_d[2] = accel_x[9:2];
              snap_d[3] = accel_y[9:2];
              snap_d[4] = accel_z[9:2];
              snap_d[5] = {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z};
            end
          end else begin
            state_d = IGNORE;
          end
        end
      end

      ADDR_ACK: begin
        if (scl_fall) begin
          bit_cnt_d = 4'd0;
          if (rw_q) begin
            state_d  = RD_DATA;
            tx_d     = next_byte;
            sda_oe_d = ~next_byte[7];
          end else begin
            state_d  = WR_DATA;
            sda_oe_d = 1'b0;
          end
        end
      end

      WR_DATA: begin
        if (scl_rise && bit_cnt_q < 4'd8) begin
          rx_d      = {rx_q[6:0], sda_s2_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          state_d  = WR_ACK;
          sda_oe_d = 1'b1;
          if (first_q) begin
            ptr_d   = rx_q;
            first_d = 1'b0;
          end else begin
            if (ptr_q == 8'hF0 && rx_q == 8'h55) init_done_d = 1'b1;
            ptr_d = ptr_q + 8'd1;
          end
        end
      end

      WR_ACK: begin
        if (scl_fall) begin
          state_d   = WR_DATA;
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
        end
      end

      RD_DATA: begin
        if (scl_rise && bit_cnt_q < 4'd8) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            state_d  = RD_ACK;
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 8'd1;
          end else begin
            // Rotate so the next MSB-first bit sits in tx_q[7] after the shift.
            tx_d     = {tx_q[6:0], tx_q[7]};
            sda_oe_d = ~tx_q[6];
          end
        end
      end

      RD_ACK: begin
        // Master NACK ends the read immediately; ACK reloads on the next fall.
        if (scl_rise && sda_s2_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (scl_fall) begin
          state_d   = RD_DATA;
          bit_cnt_d = 4'd0;
          tx_d      = next_byte;
          sda_oe_d  = ~next_byte[7];
        end
      end

      default: ;  // IDLE and IGNORE wait for START/STOP below
    endcase

    // START and STOP override whatever the state machine decided.
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_dly_q   <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_dly_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      scl_dly_q   <= scl_dly_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      sda_dly_q   <= sda_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  // NOTE: the snapshot is pure data, always rewritten before it is read, so
  // it carries no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;

endmodule

// File: doc/nunchuck_responder.md
NUNCHUCK_RESPONDER -- requirements
Module: nunchuck_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h52, the 7-bit I2C target address it answers.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port scl_in, input, 1, the I2C clock line as sampled from the pad.
REQ-005 SHALL have port sda_in, input, 1, the I2C data line as sampled from the pad.
REQ-006 SHALL have port sda_oe, output, 1; 1 pulls SDA low and 0 releases it (open-drain).
REQ-007 SHALL have ports stick_x and stick_y, input, 8 each, the joystick values to report.
REQ-008 SHALL have ports accel_x, accel_y and accel_z, input, 10 each, the accelerometer values to report.
REQ-009 SHALL have ports z and c, input, 1 each, button states; 1 = pressed.
REQ-010 SHALL have port busy, output, 1; high from an address-matched START until STOP, NACK-terminated read, or reset.
REQ-011 SHALL have port init_done, output, 1, a sticky flag set by the init write (REQ-021).

Function
REQ-012 SHALL synchronize scl_in and sda_in through 2 flops each. Edge and START/STOP detection uses the synchronized and delayed copies. Input-to-detection latency is 3 clk.
REQ-013 SHALL detect events on the synchronized lines as follows:
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Timing: clk SHALL be at least 16x the SCL frequency.
REQ-014 SHALL have FSM states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-015 SHALL handle START and STOP from any state:
- START (including repeated START) goes to ADDR and clears the bit counter.
- STOP goes to IDLE with sda_oe=0.
REQ-016 SHALL sample bits on the synchronized SCL rising edge, MSB first, and change sda_oe only on the synchronized SCL falling edge.
REQ-017 SHALL handle the address byte as follows:
- After 8 bits in ADDR, if bits[7:1]==DEV_ADDR: go to ADDR_ACK and assert sda_oe from the next SCL fall to the following SCL fall.
- Otherwise go to IGNORE with sda_oe held 0 until START/STOP.
REQ-018 SHALL keep an 8-bit register pointer ptr, reset 0x00.
REQ-019 SHALL handle writes (R/W=0):
- The first data byte loads ptr.
- Each later byte writes to the location at ptr, then ptr increments and wraps 0xFF->0x00.
- Every write byte is ACKed (WR_ACK) exactly as in REQ-017.
REQ-020 SHALL discard write data except as required by REQ-021; it has no storage beyond ptr.
REQ-021 SHALL set init_done when data 0x55 is written at ptr 0xF0. init_done is cleared only by reset.
REQ-022 SHALL, on an address-matched read (R/W=1), snapshot the report bytes in the ADDR_ACK clock and shift only the snapshot. Input changes during the read are not seen.
REQ-023 SHALL use this report byte map:
- 0: stick_x
- 1: stick_y
- 2: accel_x[9:2]
- 3: accel_y[9:2]
- 4: accel_z[9:2]
- 5: {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z}
- ptr >= 6 returns 0xFF.
REQ-024 SHALL shift read data in RD_DATA as follows:
- Drive sda_oe = ~bit, MSB first, from the SCL fall after the ACK.
- After 8 bits, release SDA (sda_oe=0) for the master ACK slot (RD_ACK) and increment ptr, wrapping.
REQ-025 SHALL handle the master response sampled in RD_ACK:
- ACK (SDA=0) loads the next byte and returns to RD_DATA.
- NACK (SDA=1) goes to IDLE with sda_oe=0 and busy=0.
REQ-026 SHALL never assert sda_oe while synchronized SCL is high, except when holding an ACK or data bit across a high phase it began driving during the preceding low phase.

Reset
REQ-027 SHALL, while rst=0 at a clk edge:
- Set the FSM to IDLE.
- Clear sda_oe, busy, init_done, ptr and the bit counter.
- Preset the synchronizer flops to 1.
REQ-028 SHALL, when reset occurs mid-transaction, release sda_oe on the next clk edge. After reset it ignores bus activity until a new START.

Verification
REQ-029 SHALL pass the reset scenario: hold rst=0 for 2 clk mid-read with sda_oe=1 -> sda_oe=0, busy=0, init_done=0 on the next edge.
REQ-030 SHALL pass the init-write scenario: START, 0xA4, 0xF0, 0x55, STOP -> sda_oe=1 in all 3 ACK slots and init_done=1 after the third byte.
REQ-031 SHALL pass the six-byte read scenario:
- Setup: write ptr 0x00 then STOP. Inputs stick_x=0x80, stick_y=0x7F, accel_x=0x2AB, accel_y=0x155, accel_z=0x3FF, z=1, c=0.
- Stimulus: START, 0xA5, read 6 bytes, with the master ACKing bytes 0-4 and NACKing byte 5.
- Required response: bytes 0x80, 0x7F, 0xAA, 0x55, 0xFF, 0xDE, then busy=0.
REQ-032 SHALL pass the address-mismatch scenario: START, 0xA6 -> sda_oe stays 0 through the ACK slot and all later bits until STOP, and busy stays 0.
REQ-033 SHALL pass the early-NACK scenario: read with NACK after byte 1, then a new read -> the new read starts at report byte 2 (0xAA).
REQ-034 SHALL pass the snapshot scenario: change stick_x from 0x80 to 0x10 during byte 0 -> 0x80 is returned; the next read returns 0x10 after ptr is rewritten to 0x00.
